hiscore_ram_arbiter: RTL and testbench
======================================

// Module: hiscore_ram_arbiter
// PURPOSE
// - Downstream of the hiscore controller; sits between it and the game work RAM port.
// - The hiscore block issues ram_write/address/data at arbitrary times, and pause only during HPS transfers.
// - This block buffers those writes and holds the CPU off the bus via cpu_hold/cpu_hold_ack.
// - It then muxes the RAM to the hiscore side and returns read data (ioctl_din) with fixed latency.
// PARAMETERS
// - ADDRESSWIDTH  10      game RAM address width; matches the hiscore block's ADDRESSWIDTH
// - FIFO_AW       2       log2 of write-FIFO depth (depth 4)
// - HOLD_TIMEOUT  16'hFFFF  cycles to wait in REQ for cpu_hold_ack before forcing OWN
// PORTS
// - clk           in   1   system clock
// - reset         in   1   asynchronous, active-high reset
// - hs_address    in   AW  hiscore RAM address (read and write)
// - hs_data       in   8   hiscore write data
// - hs_write      in   1   hiscore write strobe; one entry pushed per cycle high
// - hs_pause      in   1   hiscore requests bus for HPS upload/download
// - hs_din        out  8   registered RAM read data to hiscore ioctl_din
// - cpu_address   in   AW  CPU address
// - cpu_data      in   8   CPU write data
// - cpu_cs        in   1   CPU RAM select
// - cpu_write     in   1   CPU write enable
// - cpu_q         out  8   RAM read data to CPU (= ram_q)
// - cpu_hold      out  1   request CPU to release bus (to WAIT/BUSRQ)
// - cpu_hold_ack  in   1   CPU bus released; tie 1 if the core has no ack
// - ram_address   out  AW  RAM address
// - ram_data      out  8   RAM write data
// - ram_we        out  1   RAM write enable
// - ram_q         in   8   RAM synchronous read data (1-cycle latency)
// - busy          out  1   state != IDLE
// - overflow      out  1   sticky: push dropped because FIFO was full
// - hold_timeout  out  1   sticky: REQ exited by timeout, not ack
// BEHAVIOUR
// - Reset (async): state IDLE, FIFO empty, timeout counter 0.
//   Outputs on reset: cpu_hold=0, hs_din=0, overflow=0, hold_timeout=0; ram_* follow the CPU mux.
// - FIFO: entry {addr,data}.
//   - Push on hs_write in any state.
//   - Push when full with no pop: entry dropped, overflow<=1.
//   - Push+pop in the same cycle when full: accepted.
//   - Order is strictly preserved.
// - Mux, combinational:
//   - state OWN: ram_address = FIFO non-empty ? head.addr : hs_address; ram_data = head.data; ram_we = pop.
//   - otherwise: ram_address = cpu_address; ram_data = cpu_data; ram_we = cpu_cs & cpu_write.
//   - cpu_q = ram_q always.
// - hs_din <= ram_q every cycle. Latency is 2 clk from hs_address to hs_din.
// - FSM:
//   - IDLE: (FIFO non-empty | hs_pause) -> REQ, cpu_hold<=1.
//   - REQ: cpu_hold_ack -> OWN, counter clears. Counter reaching HOLD_TIMEOUT -> OWN, hold_timeout<=1.
//   - OWN: pop one entry per cycle while non-empty. (FIFO empty & ~hs_pause) -> REL.
//   - REL: cpu_hold<=0; RAM already muxed to CPU; 1 cycle -> IDLE.
//     A new push or hs_pause in REL is serviced by IDLE on the next pass.
// - The minimum push-to-ram_we latency with ack tied 1 is 3 cycles (IDLE, REQ, OWN).
// - CPU accesses during REQ go to RAM. During OWN they are ignored, with no write.
// - hs_pause falling while entries are pending: stay in OWN until drained.
// - Reset mid-OWN: pending entries are discarded and cpu_hold drops immediately.
// STRUCTURE
// - hiscore_pkg holds:
//   - typedef enum logic [1:0] {IDLE, REQ, OWN, REL} hs_arb_state_t;
//   - typedef struct packed {addr, data} hs_wr_entry_t; parameterized by ADDRESSWIDTH via package localparam default.
// - Sub-module hiscore_wr_fifo: registered FIFO with push, pop, full, empty, head.
// - FSM, mux and flags stay in this module.
// TESTING
// - Write 0x123/0xA5 in IDLE, ack=1: cpu_hold rises next cycle.
//   Exactly one ram_we with 0x123/0xA5 follows; back to IDLE with cpu_hold=0 within 5 cycles.
// - 5 back-to-back writes, ack held 0 for 20 cycles: overflow=1.
//   After ack, 4 ram_we in push order; the 5th entry never appears.
// - hs_pause=1, ack after 3 cycles, hs_address=0x010, RAM[0x010]=0x5A: hs_din=0x5A 2 cycles after OWN.
//   CPU write to 0x010 during OWN leaves 0x5A.
// - HOLD_TIMEOUT=8, ack never: OWN entered 8 cycles after REQ, hold_timeout=1, FIFO drains.
// - Reset pulse in OWN with 2 entries pending: all outputs at reset values, busy=0.
//   No ram_we from stale entries afterwards.
// - IDLE, cpu_cs=1, cpu_write=1, addr 0x3FF, data 0x77: ram_we=1 same cycle with CPU address/data.
//   Read back returns cpu_q=0x77.

Source files
------------

// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared types for the hiscore RAM arbiter
package hiscore_pkg;

    localparam int HS_AW = 10;
    localparam int HS_DW = 8;

    typedef enum logic [1:0] {IDLE, REQ, OWN, REL} hs_arb_state_t;

    typedef struct packed {
        logic [HS_AW-1:0] addr;
        logic [HS_DW-1:0] data;
    } hs_wr_entry_t;

endpackage

// File: rtl/hiscore_wr_fifo.sv
// rtl/hiscore_wr_fifo.sv - small registered write FIFO with combinational head
module hiscore_wr_fifo #(
    parameter int W  = 18,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - buffers hiscore writes and borrows the game RAM from the CPU
module hiscore_ram_arbiter
    import hiscore_pkg::*;
#(
    parameter int          ADDRESSWIDTH = 10,
    parameter int          FIFO_AW      = 2,
    parameter logic [15:0] HOLD_TIMEOUT = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]              hs_data,
    input  logic                    hs_write,
    input  logic                    hs_pause,
    output logic [7:0]              hs_din,
    input  logic [ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]              cpu_data,
    input  logic                    cpu_cs,
    input  logic                    cpu_write,
    output logic [7:0]              cpu_q,
    output logic                    cpu_hold,
    input  logic                    cpu_hold_ack,
    output logic [ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]              ram_data,
    output logic                    ram_we,
    input  logic [7:0]              ram_q,
    output logic                    busy,
    output logic                    overflow,
    output logic                    hold_timeout
);

    localparam int EW = ADDRESSWIDTH + 8;

    hs_arb_state_t state;
    hs_arb_state_t next_state;
    logic [15:0]   timer;
    logic          pop;
    logic          timed_out;
    logic [EW-1:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    hiscore_wr_fifo #(
        .W  (EW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (hs_write),
        .din   ({hs_address, hs_data}),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (~fifo_empty | hs_pause) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (cpu_hold_ack) begin
                    next_state = OWN;
                end else if (timer == HOLD_TIMEOUT - 16'd1) begin
                    next_state = OWN;
                    timed_out  = 1'b1;
                end
            end
            OWN: begin
                pop = ~fifo_empty;
                // Keep the bus until the queue drains, even if pause already dropped.
                if (fifo_empty & ~hs_pause) begin
                    next_state = REL;
                end
            end
            REL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= 16'd0;
            cpu_hold     <= 1'b0;
            hs_din       <= 8'd0;
            overflow     <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state    <= next_state;
            timer    <= (state == REQ && next_state == REQ) ? timer + 16'd1 : 16'd0;
            cpu_hold <= (next_state == REQ) || (next_state == OWN);
            hs_din   <= ram_q;
            if (hs_write & fifo_full & ~pop) begin
                overflow <= 1'b1;
            end
            if (timed_out) begin
                hold_timeout <= 1'b1;
            end
        end
    end

    // While owned, CPU strobes are dropped entirely; the CPU is stalled by cpu_hold.
    always_comb begin
        if (state == OWN) begin
            ram_address = fifo_empty ? hs_address : fifo_head[EW-1:8];
            ram_data    = fifo_head[7:0];
            ram_we      = pop;
        end else begin
            ram_address = cpu_address;
            ram_data    = cpu_data;
            ram_we      = cpu_cs & cpu_write;
        end
    end

    assign cpu_q = ram_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb/tb_hiscore_ram_arbiter.sv - directed self-checking bench for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hs_address;
    logic [7:0] hs_data;
    logic       hs_write;
    logic       hs_pause;
    logic [7:0] hs_din;
    logic [9:0] cpu_address;
    logic [7:0] cpu_data;
    logic       cpu_cs;
    logic       cpu_write;
    logic [7:0] cpu_q;
    logic       cpu_hold;
    logic       cpu_hold_ack;
    logic [9:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_q;
    logic       busy;
    logic       overflow;
    logic       hold_timeout;

    logic [7:0]  mem [1024];
    logic [17:0] wlog [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(
        .ADDRESSWIDTH (10),
        .FIFO_AW      (2),
        .HOLD_TIMEOUT (16'd8)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .hs_address   (hs_address),
        .hs_data      (hs_data),
        .hs_write     (hs_write),
        .hs_pause     (hs_pause),
        .hs_din       (hs_din),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .cpu_cs       (cpu_cs),
        .cpu_write    (cpu_write),
        .cpu_q        (cpu_q),
        .cpu_hold     (cpu_hold),
        .cpu_hold_ack (cpu_hold_ack),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_q        (ram_q),
        .busy         (busy),
        .overflow     (overflow),
        .hold_timeout (hold_timeout)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address] <= ram_data;
            wlog.push_back({ram_address, ram_data});
        end
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_hold(input string tag);
        for (int i = 0; i < 10 && !cpu_hold; i++) @(negedge clk);
        check(tag, cpu_hold, 1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    task automatic cpu_poke(input logic [9:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_address = a; cpu_data = d;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        hs_address = '0; hs_data = '0; hs_write = 1'b0; hs_pause = 1'b0;
        cpu_address = 10'h155; cpu_data = 8'h00; cpu_cs = 1'b0; cpu_write = 1'b0;
        cpu_hold_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_hs_din", hs_din, 0);
        check("rst_overflow", overflow, 0);
        check("rst_hold_timeout", hold_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_addr_cpu", ram_address, 10'h155);
        reset = 1'b0;
        @(negedge clk);

        // CPU pass-through write and read-back in IDLE
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_address = 10'h3FF; cpu_data = 8'h77;
        #1;
        check("cpu_we", ram_we, 1);
        check("cpu_wr_addr", ram_address, 10'h3FF);
        check("cpu_wr_data", ram_data, 8'h77);
        @(negedge clk);
        cpu_write = 1'b0;
        @(negedge clk);
        check("cpu_q_readback", cpu_q, 8'h77);
        cpu_cs = 1'b0;

        // single buffered write, ack tied high
        wlog.delete();
        hs_write = 1'b1; hs_address = 10'h123; hs_data = 8'hA5; cpu_hold_ack = 1'b1;
        @(negedge clk);
        hs_write = 1'b0;
        check("t1_hold_before", cpu_hold, 0);
        @(negedge clk);
        check("t1_hold_rise", cpu_hold, 1);
        wait_idle("t1_back_idle", 5);
        check("t1_hold_drop", cpu_hold, 0);
        check("t1_we_count", wlog.size(), 1);
        check("t1_we_entry", (wlog.size() > 0) ? wlog[0] : 18'h3FFFF, {10'h123, 8'hA5});
        check("t1_mem", mem[10'h123], 8'hA5);

        // overflow: five pushes into a depth-4 FIFO while the CPU withholds ack
        do_reset();
        wlog.delete();
        cpu_hold_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hs_write = 1'b1; hs_address = 10'h040 + 10'(i); hs_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        hs_write = 1'b0;
        check("t2_overflow", overflow, 1);
        check("t2_no_early_we", wlog.size(), 0);
        @(negedge clk);
        @(negedge clk);
        cpu_hold_ack = 1'b1;
        wait_idle("t2_back_idle", 20);
        check("t2_we_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_entry%0d", i), (i < wlog.size()) ? wlog[i] : 18'h3FFFF,
                  {10'h040 + 10'(i), 8'h10 + 8'(i)});
        end
        check("t2_no_timeout", hold_timeout, 0);

        // ack never arrives: forced ownership after the timeout
        do_reset();
        wlog.delete();
        cpu_hold_ack = 1'b0;
        hs_write = 1'b1; hs_address = 10'h2AB; hs_data = 8'h3C;
        @(negedge clk);
        hs_write = 1'b0;
        wait_hold("t4_hold");
        n = 0;
        while (!ram_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_req_cycles", n, 8);
        check("t4_hold_timeout", hold_timeout, 1);
        wait_idle("t4_back_idle", 10);
        check("t4_we_entry", (wlog.size() == 1) ? wlog[0] : 18'h3FFFF, {10'h2AB, 8'h3C});

        // pause read path and CPU write suppression while owned
        do_reset();
        cpu_poke(10'h010, 8'h5A);
        cpu_poke(10'h020, 8'h00);
        cpu_address = 10'h020;
        hs_address = 10'h010; hs_pause = 1'b1; cpu_hold_ack = 1'b0;
        wait_hold("t3_hold");
        repeat (3) @(negedge clk);
        cpu_hold_ack = 1'b1;
        @(negedge clk);
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_address = 10'h010; cpu_data = 8'hEE;
        #1;
        check("t3_own_no_we", ram_we, 0);
        check("t3_own_addr", ram_address, 10'h010);
        @(negedge clk);
        check("t3_din_latency1", hs_din, 8'h00);
        @(negedge clk);
        check("t3_din_latency2", hs_din, 8'h5A);
        cpu_cs = 1'b0; cpu_write = 1'b0;
        check("t3_mem_kept", mem[10'h010], 8'h5A);
        hs_pause = 1'b0;
        wait_idle("t3_back_idle", 5);
        check("t3_hold_drop", cpu_hold, 0);

        // reset while owning with two entries queued
        do_reset();
        wlog.delete();
        cpu_hold_ack = 1'b0;
        hs_write = 1'b1; hs_address = 10'h300; hs_data = 8'h11;
        @(negedge clk);
        hs_address = 10'h301; hs_data = 8'h22;
        @(negedge clk);
        hs_write = 1'b0;
        wait_hold("t5_hold");
        cpu_hold_ack = 1'b1;
        @(negedge clk);
        check("t5_owning", ram_we, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_hold", cpu_hold, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_we", ram_we, 0);
        check("t5_rst_din", hs_din, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_stale_we", wlog.size(), 0);
        check("t5_still_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
